collider_stream_adapter: RTL and testbench
==========================================

# collider_stream_adapter

Stream-side front end for the LBM collider. It deserialises one lattice cell's nine Q3.13 distributions from a 16-bit AXI-Stream input into a parallel register bank and drives them into the collider. It then captures the collider's post-collision results and reserialises them onto a 16-bit AXI-Stream output. It is the initiator/consumer counterpart of the collider's parallel `f_*` / `f_new_*` interface and sits between the DMA stream and the collider.

## Interface
Parameters:
- `DATA_W`, 16: width of a distribution word (Q3.13); fixed at 16 for this release.
- `CNT_W`, 16: width of `cell_count`.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `omega_in` in 16: relaxation factor 1/tau, Q3.13; sampled on acceptance of word 0 of each cell.
- `s_axis_tdata` in 16: input distribution word.
- `s_axis_tvalid` in 1: input word valid.
- `s_axis_tready` out 1: adapter accepts an input word.
- `s_axis_tlast` in 1: last cell of frame; legal only on word 8.
- `m_axis_tdata` out 16: output post-collision word.
- `m_axis_tvalid` out 1: output word valid.
- `m_axis_tready` in 1: downstream accepts the output word.
- `m_axis_tlast` out 1: asserted on word 8 of the last cell of a frame.
- `col_omega` out 16: registered omega to the collider.
- `col_f` out 144: registered distributions to the collider; word k at bits [16k+15:16k].
- `col_f_new` in 144: collider results, same packing as `col_f`.
- `col_rho` in 16: collider density.
- `col_busy` in 1: collider busy; capture is blocked while high.
- `col_newval_ready` in 1: collider result valid; capture is allowed only while high.
- `m_rho` out 16: captured density of the cell currently being drained.
- `cell_count` out CNT_W: cells completed in the current frame.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `err_framing` out 1: sticky error flag; cleared only by reset.

Word order for k = 0..8 is: null, n, ne, e, se, s, sw, w, nw.

## Operation
- States are `IDLE`, `LOAD`, `WAIT`, `DRAIN`. `IDLE` is the reset state and moves unconditionally to `LOAD` on the next clock.
- **LOAD**
  - `s_axis_tready` = 1.
  - Each handshake writes `s_axis_tdata` into `col_f` word k and increments k.
  - On the word-0 handshake, `omega_in` is registered into `col_omega`.
  - A tlast flag is set to the OR of `s_axis_tlast` across the cell.
  - A tlast seen on any word k≠8 sets `err_framing`; the flag is still set.
  - On the word-8 handshake: k←0, next state is `WAIT`.
- **WAIT**
  - `s_axis_tready` = 0; `col_f` and `col_omega` are held stable.
  - When `col_busy`=0 and `col_newval_ready`=1, on that edge: capture `col_f_new` into the output buffer and `col_rho` into `m_rho`, then go to `DRAIN`.
  - Otherwise stay in `WAIT` indefinitely; there is no timeout.
- **DRAIN**
  - `m_axis_tvalid` = 1; `m_axis_tdata` = buffer word j.
  - `m_axis_tlast` = tlast flag AND (j==8).
  - Each handshake increments j.
  - On the word-8 handshake: j←0 and next state is `LOAD`.
    - If the tlast flag is set: `frame_done` pulses for the next cycle, `cell_count`←0, and the flag clears.
    - Otherwise `cell_count` increments, wrapping modulo 2^CNT_W.
- No arithmetic is performed on data words; they pass bit-exact. `cell_count` is unsigned.
- At most one cell is in flight; input and output phases do not overlap.

## Timing
- Reset values: `s_axis_tready`, `m_axis_tvalid`, `m_axis_tlast`, `frame_done` and `err_framing` are 0. `m_axis_tdata`, `col_f`, `col_omega`, `m_rho` and `cell_count` are all zero. k=j=0.
- `s_axis_tready` is first high in the second rising edge after `rst_n` deasserts (IDLE→LOAD).
- `col_f` word 8 updates on the edge of the word-8 handshake. The collider's combinational path has one full cycle to settle before the earliest capture edge.
- Latency from the word-8 input handshake to the first `m_axis_tvalid`: 2 cycles minimum (1 in `WAIT`), plus any cycles spent stalled on `col_busy` or `col_newval_ready`.
- Minimum throughput: 19 cycles per cell (9 in, 1 wait, 9 out).
- AXI rules:
  - `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` are held stable while valid && !ready.
  - `m_axis_tvalid` never depends combinationally on `m_axis_tready`.
- `s_axis_tvalid` gaps in `LOAD` simply pause k.
- `m_axis_tready` low in `DRAIN` pauses j.
- Reset asserted mid-operation forces `IDLE` immediately and clears all state; any partial cell is discarded.

## Test plan
- Reset release: `s_axis_tready`=0 during reset and on the first edge after release, then 1; all other outputs are 0.
- Single cell with a stub collider (`col_f_new`=`col_f`, `col_rho`=0x2001, ready=1, busy=0):
  - Stimulus: input words 0x0e39, 0x038e×4, 0x00e4×4.
  - Required: identical 9 words out in the same order; `m_rho`=0x2001; first `m_axis_tvalid` 2 cycles after the word-8 handshake; `cell_count`=1.
- Output backpressure: toggle `m_axis_tready` pseudo-randomly → data and tlast are stable while stalled, no word is lost or duplicated, and the next cell is not accepted until word 8 drains.
- Collider stall: hold `col_busy`=1 for 5 cycles after load → remains in `WAIT` with `col_f` unchanged and `s_axis_tready`=0; capture happens on the first edge with busy=0 and ready=1.
- Frame of 3 cells with tlast on word 8 of cell 3 → `m_axis_tlast` only on output word 27, `frame_done` is a single pulse, `cell_count` returns to 0. Repeat with tlast on word 4 → `err_framing`=1 and it stays set.
- Reset asserted during `DRAIN` at j=4 → outputs are zero immediately; after release, a fresh cell streams correctly from word 0.

Source files
------------

// File: rtl/collider_stream_adapter.sv
// Stream front end for the LBM collider: deserialises nine Q3.13 words per cell
// into the collider's parallel inputs, then reserialises the captured results.
module collider_stream_adapter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   omega_in,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [DATA_W-1:0]   col_omega,
  output logic [9*DATA_W-1:0] col_f,
  input  logic [9*DATA_W-1:0] col_f_new,
  input  logic [DATA_W-1:0]   col_rho,
  input  logic                col_busy,
  input  logic                col_newval_ready,
  output logic [DATA_W-1:0]   m_rho,
  output logic [CNT_W-1:0]    cell_count,
  output logic                frame_done,
  output logic                err_framing
);

  localparam logic [3:0] LAST = 4'd8;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

  state_t state, state_nxt;

  logic [3:0]             k, j;
  logic [8:0][DATA_W-1:0] f_q;
  logic [8:0][DATA_W-1:0] obuf;
  logic                   tlast_flag;
  logic                   s_hs, m_hs, cap;

  assign col_f        = f_q;
  assign m_axis_tdata = obuf[j];

  assign s_hs = (state == LOAD)  && s_axis_tvalid;
  assign m_hs = (state == DRAIN) && m_axis_tready;
  assign cap  = (state == WAIT)  && !col_busy && col_newval_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE:  state_nxt = LOAD;
      LOAD: begin
        s_axis_tready = 1'b1;
        if (s_hs && k == LAST) state_nxt = WAIT;
      end
      WAIT:  if (cap) state_nxt = DRAIN;
      DRAIN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = tlast_flag && (j == LAST);
        if (m_hs && j == LAST) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k           <= '0;
      j           <= '0;
      f_q         <= '0;
      obuf        <= '0;
      col_omega   <= '0;
      m_rho       <= '0;
      tlast_flag  <= 1'b0;
      err_framing <= 1'b0;
      frame_done  <= 1'b0;
      cell_count  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (s_hs) begin
        f_q[k] <= s_axis_tdata;
        if (k == 4'd0) col_omega <= omega_in;
        // tlast off word 8 is flagged but still marks the cell as frame end
        if (s_axis_tlast) begin
          tlast_flag <= 1'b1;
          if (k != LAST) err_framing <= 1'b1;
        end
        k <= (k == LAST) ? 4'd0 : k + 4'd1;
      end
      if (cap) begin
        obuf  <= col_f_new;
        m_rho <= col_rho;
      end
      if (m_hs) begin
        j <= (j == LAST) ? 4'd0 : j + 4'd1;
        if (j == LAST) begin
          if (tlast_flag) begin
            frame_done <= 1'b1;
            cell_count <= '0;
            tlast_flag <= 1'b0;
          end else begin
            cell_count <= cell_count + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_collider_stream_adapter.sv
// Randomised bench for collider_stream_adapter; the collider is modelled as
// col_f XOR a bench-chosen mask so results are predictable per cell.
module tb_collider_stream_adapter;

  typedef logic [15:0] cell_t [9];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  omega_in = '0;
  logic [15:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [15:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
  logic [15:0]  col_omega;
  logic [143:0] col_f;
  logic [143:0] col_f_new;
  logic [15:0]  col_rho = '0;
  logic         col_busy = 1'b0;
  logic         col_newval_ready = 1'b1;
  logic [15:0]  m_rho;
  logic [15:0]  cell_count;
  logic         frame_done;
  logic         err_framing;
  logic [143:0] xmask = '0;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  collider_stream_adapter #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .omega_in(omega_in),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .col_omega(col_omega), .col_f(col_f), .col_f_new(col_f_new),
    .col_rho(col_rho), .col_busy(col_busy), .col_newval_ready(col_newval_ready),
    .m_rho(m_rho), .cell_count(cell_count), .frame_done(frame_done),
    .err_framing(err_framing)
  );

  always #5 clk = ~clk;
  assign col_f_new = col_f ^ xmask;

  always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  function automatic logic [143:0] pack(input cell_t w);
    logic [143:0] p;
    for (int i = 0; i < 9; i++) p[16*i +: 16] = w[i];
    return p;
  endfunction

  function automatic cell_t rand_cell();
    cell_t w;
    for (int i = 0; i < 9; i++) w[i] = 16'($urandom);
    return w;
  endfunction

  function automatic logic [143:0] rand_mask();
    return 144'({$urandom, $urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    col_busy = 1'b0; col_newval_ready = 1'b1; xmask = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_cell(input cell_t w, input int lastpos, input int gap_pct,
                           output logic [15:0] om0);
    om0 = '0;
    for (int i = 0; i < 9; i++) begin
      int t;
      t = 0;
      while ($urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = w[i];
      s_axis_tlast  = (i == lastpos);
      omega_in      = 16'($urandom);
      if (i == 0) om0 = omega_in;
      while (!s_axis_tready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        checks++; errors++;
        $display("FAIL send_timeout word %0d: tready=%b required 1", i, s_axis_tready);
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    omega_in      = 16'($urandom);
  endtask

  // Returns negedges waited until m_axis_tvalid (100 = gave up).
  task automatic wait_valid(output int n);
    n = 0;
    while (!m_axis_tvalid && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Drains n words; counts AXI stability / overlap violations in viol.
  task automatic recv_words(input int n, input int rdy_pct, output cell_t got,
                            output logic [8:0] lasts, output int viol);
    viol = 0; lasts = '0;
    for (int i = 0; i < 9; i++) got[i] = '0;
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      while (!(m_axis_tvalid && m_axis_tready) && t < 200) begin
        logic [15:0] d;
        logic l, v;
        v = m_axis_tvalid; d = m_axis_tdata; l = m_axis_tlast;
        @(negedge clk);
        t++;
        if (v && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || m_axis_tlast !== l)) viol++;
        if (m_axis_tvalid && s_axis_tready) viol++;
        m_axis_tready = ($urandom_range(99) < rdy_pct);
      end
      if (t >= 200) viol += 100;
      got[i] = m_axis_tdata;
      lasts[i] = m_axis_tlast;
      @(negedge clk);
    end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, frame_done, err_framing} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 00000",
        {s_axis_tready, m_axis_tvalid, m_axis_tlast, frame_done, err_framing});
    end
    checks++;
    if ({m_axis_tdata, col_omega, m_rho, cell_count} !== 64'd0 || col_f !== 144'd0) begin
      errors++; $display("FAIL reset_data: tdata=%h omega=%h rho=%h count=%0d col_f=%h required all 0",
        m_axis_tdata, col_omega, m_rho, cell_count, col_f);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL reset_release_ready: got %b required 0", s_axis_tready);
    end
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++; $display("FAIL load_ready: got %b required 1", s_axis_tready);
    end
  endtask

  task automatic test_single_cell();
    cell_t w, got;
    logic [8:0] lasts;
    logic [15:0] om;
    int viol, n;
    apply_reset();
    w = '{16'h0e39, 16'h038e, 16'h038e, 16'h038e, 16'h038e,
          16'h00e4, 16'h00e4, 16'h00e4, 16'h00e4};
    col_rho = 16'h2001;
    send_cell(w, -1, 0, om);
    checks++;
    if (col_f !== pack(w)) begin
      errors++; $display("FAIL single_col_f: got %h required %h", col_f, pack(w));
    end
    checks++;
    if (col_omega !== om) begin
      errors++; $display("FAIL single_omega: got %h required %h", col_omega, om);
    end
    checks++;
    if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL single_wait: tvalid=%b tready=%b required 0 0", m_axis_tvalid, s_axis_tready);
    end
    wait_valid(n);
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL single_latency: got %0d extra cycles required 1", n);
    end
    recv_words(9, 100, got, lasts, viol);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== w[i]) begin
        errors++; $display("FAIL single_word%0d: got %h required %h", i, got[i], w[i]);
      end
    end
    checks++;
    if (lasts !== 9'd0 || viol != 0) begin
      errors++; $display("FAIL single_tlast: lasts=%b viol=%0d required 0 0", lasts, viol);
    end
    checks++;
    if (m_rho !== 16'h2001 || cell_count !== 16'd1) begin
      errors++; $display("FAIL single_rho_count: rho=%h count=%0d required 2001 1", m_rho, cell_count);
    end
  endtask

  task automatic test_backpressure();
    cell_t w, got;
    logic [8:0] lasts;
    logic [15:0] om, rho;
    logic [143:0] mask;
    int viol, n;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      w = rand_cell(); mask = rand_mask(); rho = 16'($urandom);
      xmask = mask; col_rho = rho;
      send_cell(w, -1, 30, om);
      wait_valid(n);
      // the collider moves on once captured; the adapter must not follow
      xmask = rand_mask(); col_rho = ~rho;
      recv_words(9, 40, got, lasts, viol);
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (got[i] !== (w[i] ^ mask[16*i +: 16])) begin
          errors++; $display("FAIL bp_cell%0d_word%0d: got %h required %h", c, i, got[i], w[i] ^ mask[16*i +: 16]);
        end
      end
      checks++;
      if (viol != 0 || n != 1 || lasts !== 9'd0) begin
        errors++; $display("FAIL bp_cell%0d_axi: viol=%0d latency=%0d lasts=%b required 0 1 0", c, viol, n, lasts);
      end
      checks++;
      if (m_rho !== rho || cell_count !== 16'(c + 1)) begin
        errors++; $display("FAIL bp_cell%0d_rho_count: rho=%h count=%0d required %h %0d", c, m_rho, cell_count, rho, c + 1);
      end
    end
  endtask

  task automatic test_collider_stall();
    cell_t w, got;
    logic [8:0] lasts;
    logic [15:0] om;
    logic [143:0] mask;
    int viol, n, bad;
    apply_reset();
    w = rand_cell();
    col_busy = 1'b1; col_rho = 16'h1234;
    send_cell(w, -1, 0, om);
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || col_f !== pack(w)) bad++;
    end
    col_busy = 1'b0; col_newval_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || col_f !== pack(w)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stall_hold: %0d bad cycles required 0", bad);
    end
    mask = rand_mask(); xmask = mask; col_newval_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++; $display("FAIL stall_capture: tvalid=%b required 1", m_axis_tvalid);
    end
    wait_valid(n);
    recv_words(9, 70, got, lasts, viol);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== (w[i] ^ mask[16*i +: 16])) begin
        errors++; $display("FAIL stall_word%0d: got %h required %h", i, got[i], w[i] ^ mask[16*i +: 16]);
      end
    end
    checks++;
    if (viol != 0 || m_rho !== 16'h1234) begin
      errors++; $display("FAIL stall_axi_rho: viol=%0d rho=%h required 0 1234", viol, m_rho);
    end
  endtask

  task automatic test_frame();
    cell_t w, got;
    logic [8:0] lasts;
    logic [26:0] all_l;
    logic [15:0] om;
    int viol, n, fd0;
    apply_reset();
    #1 fd0 = fd_cnt;
    all_l = '0;
    for (int c = 0; c < 3; c++) begin
      w = rand_cell(); xmask = rand_mask();
      send_cell(w, (c == 2) ? 8 : -1, 20, om);
      wait_valid(n);
      recv_words(9, 60, got, lasts, viol);
      all_l[9*c +: 9] = lasts;
      checks++;
      if (cell_count !== 16'((c == 2) ? 0 : c + 1) || viol != 0) begin
        errors++; $display("FAIL frame_count%0d: count=%0d viol=%0d required %0d 0", c, cell_count, viol, (c == 2) ? 0 : c + 1);
      end
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++; $display("FAIL frame_done_pulse: got %b required 1", frame_done);
    end
    @(negedge clk);
    #1;
    checks++;
    if (frame_done !== 1'b0 || fd_cnt - fd0 != 1) begin
      errors++; $display("FAIL frame_done_single: done=%b pulses=%0d required 0 1", frame_done, fd_cnt - fd0);
    end
    checks++;
    if (all_l !== 27'h4000000 || err_framing !== 1'b0) begin
      errors++; $display("FAIL frame_tlast: lasts=%h err=%b required 4000000 0", all_l, err_framing);
    end
  endtask

  task automatic test_framing_err();
    cell_t w, got;
    logic [8:0] lasts;
    logic [15:0] om;
    int viol, n;
    w = rand_cell(); xmask = '0;
    send_cell(w, 4, 0, om);
    checks++;
    if (err_framing !== 1'b1) begin
      errors++; $display("FAIL framing_err_set: got %b required 1", err_framing);
    end
    wait_valid(n);
    recv_words(9, 80, got, lasts, viol);
    checks++;
    if (lasts !== 9'h100 || cell_count !== 16'd0 || got[4] !== w[4]) begin
      errors++; $display("FAIL framing_err_cell: lasts=%b count=%0d w4=%h required 100000000 0 %h", lasts, cell_count, got[4], w[4]);
    end
    w = rand_cell();
    send_cell(w, -1, 0, om);
    wait_valid(n);
    recv_words(9, 80, got, lasts, viol);
    checks++;
    if (err_framing !== 1'b1 || cell_count !== 16'd1 || lasts !== 9'd0) begin
      errors++; $display("FAIL framing_err_sticky: err=%b count=%0d lasts=%b required 1 1 0", err_framing, cell_count, lasts);
    end
  endtask

  task automatic test_reset_mid_drain();
    cell_t w, got;
    logic [8:0] lasts;
    logic [15:0] om;
    int viol, n;
    apply_reset();
    w = rand_cell(); xmask = '0; col_rho = 16'h5a5a;
    send_cell(w, -1, 0, om);
    wait_valid(n);
    recv_words(4, 100, got, lasts, viol);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[4]) begin
      errors++; $display("FAIL mid_drain_pos: tvalid=%b tdata=%h required 1 %h", m_axis_tvalid, m_axis_tdata, w[4]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_axis_tvalid, s_axis_tready, m_axis_tlast} !== 3'b0 || m_axis_tdata !== 16'd0 ||
        m_rho !== 16'd0 || col_f !== 144'd0 || col_omega !== 16'd0) begin
      errors++; $display("FAIL mid_reset_clear: tvalid=%b tready=%b tdata=%h rho=%h required all 0",
        m_axis_tvalid, s_axis_tready, m_axis_tdata, m_rho);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = rand_cell(); xmask = rand_mask();
    send_cell(w, -1, 10, om);
    wait_valid(n);
    recv_words(9, 75, got, lasts, viol);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (got[i] !== (w[i] ^ xmask[16*i +: 16])) begin
        errors++; $display("FAIL post_reset_word%0d: got %h required %h", i, got[i], w[i] ^ xmask[16*i +: 16]);
      end
    end
    checks++;
    if (cell_count !== 16'd1 || viol != 0) begin
      errors++; $display("FAIL post_reset_count: count=%0d viol=%0d required 1 0", cell_count, viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_cell();
    test_backpressure();
    test_collider_stall();
    test_frame();
    test_framing_err();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
